// File: rtl/uart_autobaud.sv
// Purpose : auto-baud calibration; measures a host-sent 0x55 (8N1) on raw rx and drives baud_div.
// Latency : rx edges seen 3 cycles late (2-flop sync + edge reg); lock lands cand cycles after stop rise.
// Backpr. : none; cal_start is a request pulse, dropped while busy. No flow control on outputs.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   rx              raw asynchronous UART line
//   cal_start       calibration request pulse (ignored while busy)
//   baud_div        divider driven to the UART receiver
//   locked          a calibrated divider is in use
//   busy            calibration in progress
//   cal_done        one-cycle pulse on successful lock
//   cal_err         sticky error flag, cleared by the next accepted cal_start
//
// Optional feature: define AUTOBAUD_SEGMENT_CHECK_EN to check every edge-to-edge
// segment up to t8 against the first low segment (rejects non-0x55 characters).

module uart_autobaud #(
   parameter int BAUD_DIV_WIDTH = 16,
   parameter int DEFAULT_DIV    = 434,
   parameter int MIN_DIV        = 16,
   parameter int IDLE_CYCLES    = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx,
   input  logic                      cal_start,
   output logic [BAUD_DIV_WIDTH-1:0] baud_div,
   output logic                      locked,
   output logic                      busy,
   output logic                      cal_done,
   output logic                      cal_err
);

   // Measure counter holds up to eight bit times of the largest divider.
   localparam int CW = BAUD_DIV_WIDTH + 3;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ARM       = 3'd1;
   localparam logic [2:0] S_WAIT_FALL = 3'd2;
   localparam logic [2:0] S_MEASURE   = 3'd3;
   localparam logic [2:0] S_STOP_RISE = 3'd4;
   localparam logic [2:0] S_STOP_CHK  = 3'd5;

   localparam logic [CW-1:0]             CNT_MAX   = '1;
   localparam logic [CW-1:0]             IDLE_LIM  = CW'(IDLE_CYCLES);
   localparam logic [CW:0]               ROUND_ADD = (CW+1)'(4);
   localparam logic [BAUD_DIV_WIDTH-1:0] MIN_LIM   = BAUD_DIV_WIDTH'(MIN_DIV);
   localparam logic [BAUD_DIV_WIDTH-1:0] DEF_DIV   = BAUD_DIV_WIDTH'(DEFAULT_DIV);

   // Synchronizer and edge register
   logic rx_s1_q, rx_s2_q, rx_prev_q;

   logic [2:0]                state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [1:0]                fall_cnt_q, fall_cnt_d;
   logic [BAUD_DIV_WIDTH-1:0] cand_q, cand_d;
   logic [BAUD_DIV_WIDTH-1:0] baud_div_q, baud_div_d;
   logic                      locked_q, locked_d;
   logic                      busy_q, busy_d;
   logic                      cal_done_q, cal_done_d;
   logic                      cal_err_q, cal_err_d;

   logic                      fall, rise, edge_any;
   logic [CW-1:0]             cnt_inc;
   logic                      cnt_sat;
   logic [CW:0]               cand_sum;
   logic [CW:0]               cand_shr;
   logic [BAUD_DIV_WIDTH-1:0] cand_new;
   logic                      cand_small;
   logic                      err_exit;

`ifdef AUTOBAUD_SEGMENT_CHECK_EN
   logic [CW-1:0] seg0_q, seg0_d;
   logic          seg0_vld_q, seg0_vld_d;
   logic [CW-1:0] last_edge_q, last_edge_d;
   logic [CW-1:0] seg_len, seg_diff;
   logic          seg_bad;
`endif

   // Edges are taken on the synchronized line against its previous value.
   assign fall     = rx_prev_q & ~rx_s2_q;
   assign rise     = ~rx_prev_q & rx_s2_q;
   assign edge_any = fall | rise;

   // Saturating increment: the counter parks at all-ones, which is the timeout.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
   assign cnt_sat = (cnt_inc == CNT_MAX);

   // cnt_inc at the t8 edge equals the full eight-bit interval; round to nearest.
   assign cand_sum = {1'b0, cnt_inc} + ROUND_ADD;
   assign cand_shr = cand_sum >> 3;
   assign cand_new = cand_shr[BAUD_DIV_WIDTH-1:0];
   // Any bit above the divider width means the truncated value wrapped to a tiny
   // number, so it is rejected exactly as a below-minimum result would be.
   assign cand_small = (|cand_shr[CW:BAUD_DIV_WIDTH]) || (cand_new < MIN_LIM);

`ifdef AUTOBAUD_SEGMENT_CHECK_EN
   assign seg_len  = cnt_inc - last_edge_q;
   assign seg_diff = (seg_len >= seg0_q) ? (seg_len - seg0_q) : (seg0_q - seg_len);
   assign seg_bad  = seg0_vld_q && (seg_diff > (seg0_q >> 2));
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fall_cnt_d = fall_cnt_q;
      cand_d     = cand_q;
      baud_div_d = baud_div_q;
      locked_d   = locked_q;
      busy_d     = busy_q;
      cal_done_d = 1'b0;
      cal_err_d  = cal_err_q;
      err_exit   = 1'b0;
`ifdef AUTOBAUD_SEGMENT_CHECK_EN
      seg0_d      = seg0_q;
      seg0_vld_d  = seg0_vld_q;
      last_edge_d = last_edge_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cal_start) begin
               state_d   = S_ARM;
               busy_d    = 1'b1;
               locked_d  = 1'b0;
               cal_err_d = 1'b0;
               cnt_d     = '0;
            end
         end

         // Require a run of IDLE_CYCLES consecutive highs before trusting the line.
         S_ARM: begin
            if (rx_s2_q) begin
               if (cnt_inc >= IDLE_LIM) begin
                  state_d = S_WAIT_FALL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else begin
               cnt_d = '0;
            end
         end

         // Start bit (t0); no timeout here by design.
         S_WAIT_FALL: begin
            if (fall) begin
               state_d    = S_MEASURE;
               cnt_d      = '0;
               fall_cnt_d = '0;
`ifdef AUTOBAUD_SEGMENT_CHECK_EN
               seg0_vld_d  = 1'b0;
               last_edge_d = '0;
`endif
            end
         end

         // 0x55 gives falls at t2, t4, t6, t8 after the start edge.
         S_MEASURE: begin
            cnt_d = cnt_inc;
            if (cnt_sat) begin
               err_exit = 1'b1;
`ifdef AUTOBAUD_SEGMENT_CHECK_EN
            end else if (edge_any && seg_bad) begin
               err_exit = 1'b1;
`endif
            end else if (fall) begin
               if (fall_cnt_q == 2'd3) begin
                  if (cand_small) begin
                     err_exit = 1'b1;
                  end else begin
                     cand_d  = cand_new;
                     state_d = S_STOP_RISE;
                     cnt_d   = '0;
                  end
               end else begin
                  fall_cnt_d = fall_cnt_q + 2'd1;
               end
            end
`ifdef AUTOBAUD_SEGMENT_CHECK_EN
            // First closed segment (t0->t1) becomes the reference length.
            if (edge_any) begin
               last_edge_d = cnt_inc;
               if (!seg0_vld_q) begin
                  seg0_d     = seg_len;
                  seg0_vld_d = 1'b1;
               end
            end
`endif
         end

         // Counter restarts per phase so each wait gets its own full timeout.
         S_STOP_RISE: begin
            if (cnt_sat) begin
               err_exit = 1'b1;
            end else if (rise) begin
               state_d = S_STOP_CHK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         // Stop bit must read high for a full measured bit time.
         S_STOP_CHK: begin
            if (!rx_s2_q) begin
               err_exit = 1'b1;
            end else if (cnt_inc == {3'b000, cand_q}) begin
               state_d    = S_IDLE;
               baud_div_d = cand_q;
               locked_d   = 1'b1;
               cal_done_d = 1'b1;
               busy_d     = 1'b0;
            end else if (cnt_sat) begin
               err_exit = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Common error exit; baud_div keeps its previous value.
      if (err_exit) begin
         state_d   = S_IDLE;
         cal_err_d = 1'b1;
         locked_d  = 1'b0;
         busy_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         fall_cnt_q <= '0;
         cand_q     <= '0;
         baud_div_q <= DEF_DIV;
         locked_q   <= 1'b0;
         busy_q     <= 1'b0;
         cal_done_q <= 1'b0;
         cal_err_q  <= 1'b0;
`ifdef AUTOBAUD_SEGMENT_CHECK_EN
         seg0_q      <= '0;
         seg0_vld_q  <= 1'b0;
         last_edge_q <= '0;
`endif
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fall_cnt_q <= fall_cnt_d;
         cand_q     <= cand_d;
         baud_div_q <= baud_div_d;
         locked_q   <= locked_d;
         busy_q     <= busy_d;
         cal_done_q <= cal_done_d;
         cal_err_q  <= cal_err_d;
`ifdef AUTOBAUD_SEGMENT_CHECK_EN
         seg0_q      <= seg0_d;
         seg0_vld_q  <= seg0_vld_d;
         last_edge_q <= last_edge_d;
`endif
      end
   end

   assign baud_div = baud_div_q;
   assign locked   = locked_q;
   assign busy     = busy_q;
   assign cal_done = cal_done_q;
   assign cal_err  = cal_err_q;

endmodule
